// File: rtl/soc_sysid_arbiter.sv
// soc_sysid_arbiter: round-robin two-requester read arbiter in front of a system-ID slave
module soc_sysid_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_read,
  input  logic        m0_address,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic        m1_read,
  input  logic        m1_address,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic        s_address,
  input  logic [31:0] s_readdata
);
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("soc_sysid_arbiter: READ_LATENCY must be 1..4");
  end
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  localparam logic [1:0] LOAD = 2'(READ_LATENCY - 1);
  state_t      r_state;
  logic [1:0]  r_cnt;
  logic        r_last;
  logic        r_idx;
  logic        r_saddr;
  logic        r_dv0;
  logic        r_dv1;
  logic [31:0] r_data;
  logic        w_idle;
  logic        w_g0;
  logic        w_g1;
  // acceptance is gated by reset_n so nothing is granted while reset is held
  assign w_idle           = reset_n && r_state == IDLE;
  assign w_g0             = w_idle && m0_read && (!m1_read || r_last);
  assign w_g1             = w_idle && m1_read && (!m0_read || !r_last);
  assign m0_waitrequest   = m0_read && !w_g0;
  assign m1_waitrequest   = m1_read && !w_g1;
  assign m0_readdata      = r_data;
  assign m1_readdata      = r_data;
  assign m0_readdatavalid = r_dv0;
  assign m1_readdatavalid = r_dv1;
  assign s_address        = r_saddr;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_last  <= 1'b1;
      r_idx   <= 1'b0;
      r_saddr <= 1'b0;
      r_dv0   <= 1'b0;
      r_dv1   <= 1'b0;
      r_data  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: if (w_g0 || w_g1) begin
          r_state <= ACCESS;
          r_cnt   <= LOAD;
          r_idx   <= w_g1;
          r_saddr <= w_g1 ? m1_address : m0_address;
        end
        ACCESS: if (r_cnt == 2'd0) begin
          r_state <= RESPOND;
          r_data  <= s_readdata;
          r_saddr <= 1'b0;
          r_dv0   <= !r_idx;
          r_dv1   <= r_idx;
        end else begin
          r_cnt <= r_cnt - 2'd1;
        end
        RESPOND: begin
          r_state <= IDLE;
          r_last  <= r_idx;
          r_dv0   <= 1'b0;
          r_dv1   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soc_sysid_arbiter.sv
// tb_soc_sysid_arbiter: scoreboard bench for READ_LATENCY=1 and READ_LATENCY=3 instances
module tb_soc_sysid_arbiter;
  localparam logic [31:0] SYSID = 32'h6646062E;
  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  logic clk;
  logic reset_n;
  logic a0_read, a0_addr, a0_wait, a0_dv, a1_read, a1_addr, a1_wait, a1_dv, a_sa;
  logic b0_read, b0_addr, b0_wait, b0_dv, b1_read, b1_addr, b1_wait, b1_dv, b_sa;
  logic [31:0] a0_rd, a1_rd, a_srd, b0_rd, b1_rd, b_srd;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   t;
  exp_t q1[$];
  exp_t q3[$];
  assign a_srd = a_sa ? SYSID : 32'd0;
  assign b_srd = b_sa ? SYSID : 32'd0;
  soc_sysid_arbiter #(.READ_LATENCY(1)) u_dut1 (
    .clock(clk), .reset_n(reset_n),
    .m0_read(a0_read), .m0_address(a0_addr), .m0_waitrequest(a0_wait),
    .m0_readdata(a0_rd), .m0_readdatavalid(a0_dv),
    .m1_read(a1_read), .m1_address(a1_addr), .m1_waitrequest(a1_wait),
    .m1_readdata(a1_rd), .m1_readdatavalid(a1_dv),
    .s_address(a_sa), .s_readdata(a_srd)
  );
  soc_sysid_arbiter #(.READ_LATENCY(3)) u_dut3 (
    .clock(clk), .reset_n(reset_n),
    .m0_read(b0_read), .m0_address(b0_addr), .m0_waitrequest(b0_wait),
    .m0_readdata(b0_rd), .m0_readdatavalid(b0_dv),
    .m1_read(b1_read), .m1_address(b1_addr), .m1_waitrequest(b1_wait),
    .m1_readdata(b1_rd), .m1_readdatavalid(b1_dv),
    .s_address(b_sa), .s_readdata(b_srd)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (a0_dv || a1_dv) begin
      chk("d1_both_valid", {31'd0, a0_dv && a1_dv}, 32'd0);
      if (q1.size() == 0) chk("d1_spurious_valid", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("d1_port", {31'd0, a1_dv}, e.port);
        chk("d1_data", a1_dv ? a1_rd : a0_rd, e.data);
        chk("d1_cycle", cyc, e.cyc);
      end
    end
    if (b0_dv || b1_dv) begin
      chk("d3_both_valid", {31'd0, b0_dv && b1_dv}, 32'd0);
      if (q3.size() == 0) chk("d3_spurious_valid", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        chk("d3_port", {31'd0, b1_dv}, e.port);
        chk("d3_data", b1_dv ? b1_rd : b0_rd, e.data);
        chk("d3_cycle", cyc, e.cyc);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    {a0_read, a0_addr, a1_read, a1_addr} = 4'b1000;
    {b0_read, b0_addr, b1_read, b1_addr} = 4'b0000;
    repeat (3) step();
    @(negedge clk);
    chk("rst_wait0", a0_wait, 1);
    chk("rst_wait1", a1_wait, 0);
    chk("rst_rdata", a0_rd, 0);
    chk("rst_valid", a0_dv, 0);
    chk("rst_saddr", a_sa, 0);
    step();
    reset_n = 1'b1;
    a0_read = 1'b0;
    // contention on the first cycle after reset
    step();
    {a0_read, a0_addr, a1_read, a1_addr} = 4'b1110;
    t = cyc;
    q1.push_back(exp_t'{0, SYSID, t + 2});
    @(negedge clk);
    chk("con_wait0", a0_wait, 0);
    chk("con_wait1_t0", a1_wait, 1);
    step();
    a0_read = 1'b0;
    @(negedge clk);
    chk("con_wait1_t1", a1_wait, 1);
    chk("con_saddr", a_sa, 1);
    step();
    @(negedge clk);
    chk("con_wait1_t2", a1_wait, 1);
    chk("con_saddr_resp", a_sa, 0);
    step();
    q1.push_back(exp_t'{1, 32'd0, t + 5});
    @(negedge clk);
    chk("con_wait1_t3", a1_wait, 0);
    step();
    a1_read = 1'b0;
    repeat (2) step();
    // fairness: both requesters held continuously
    {a0_read, a0_addr, a1_read, a1_addr} = 4'b1110;
    t = cyc;
    for (int k = 0; k < 8; k++) q1.push_back(exp_t'{k % 2, (k % 2) ? 32'd0 : SYSID, t + 3 * k + 2});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fair_wait0", a0_wait, k % 2);
      chk("fair_wait1", a1_wait, (k % 2) ^ 1);
      repeat (3) step();
    end
    a0_read = 1'b0;
    a1_read = 1'b0;
    // withdrawn stalled read leaves round-robin untouched
    {a0_read, a0_addr} = 2'b10;
    t = cyc;
    q1.push_back(exp_t'{0, 32'd0, t + 2});
    @(negedge clk);
    chk("wd_wait0", a0_wait, 0);
    step();
    a0_read = 1'b0;
    a1_read = 1'b1;
    @(negedge clk);
    chk("wd_stall1", a1_wait, 1);
    step();
    a1_read = 1'b0;
    step();
    {a0_read, a0_addr, a1_read, a1_addr} = 4'b1111;
    q1.push_back(exp_t'{1, SYSID, t + 5});
    @(negedge clk);
    chk("wd_rr_wait0", a0_wait, 1);
    chk("wd_rr_wait1", a1_wait, 0);
    step();
    a0_read = 1'b0;
    a1_read = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("hold_rdata0", a0_rd, SYSID);
    chk("hold_rdata1", a1_rd, SYSID);
    chk("idle_saddr", a_sa, 0);
    // READ_LATENCY=3 instance
    step();
    {b1_read, b1_addr} = 2'b10;
    t = cyc;
    q3.push_back(exp_t'{1, 32'd0, t + 4});
    @(negedge clk);
    chk("lat_wait1", b1_wait, 0);
    step();
    b1_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat_saddr0", b_sa, 0);
      step();
    end
    step();
    {b1_read, b1_addr} = 2'b11;
    t = cyc;
    q3.push_back(exp_t'{1, SYSID, t + 4});
    @(negedge clk);
    chk("lat_wait1b", b1_wait, 0);
    step();
    b1_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat_saddr1", b_sa, 1);
      step();
    end
    @(negedge clk);
    chk("lat_saddr_end", b_sa, 0);
    step();
    // reset during ACCESS aborts the transaction
    {b1_read, b1_addr} = 2'b11;
    step();
    b1_read = 1'b0;
    step();
    reset_n = 1'b0;
    @(negedge clk);
    chk("rmo_saddr", b_sa, 0);
    chk("rmo_valid", b1_dv, 0);
    chk("rmo_rdata", b1_rd, 0);
    step();
    reset_n = 1'b1;
    repeat (8) step();
    {b0_read, b0_addr, b1_read, b1_addr} = 4'b1011;
    t = cyc;
    q3.push_back(exp_t'{0, 32'd0, t + 4});
    q3.push_back(exp_t'{1, SYSID, t + 9});
    @(negedge clk);
    chk("rmo_wait0", b0_wait, 0);
    chk("rmo_wait1", b1_wait, 1);
    step();
    b0_read = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("rmo_wait1_acc", b1_wait, 0);
    step();
    b1_read = 1'b0;
    repeat (12) step();
    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
